// File: rtl/async_fifo16_wr_arbiter_pkg.sv
// Shared constants and state encoding for the async_fifo16 write-side arbiter.
package async_lib_pkg;

   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned CREDIT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned GAP_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_GAP
   } wr_state_e;

endpackage

// File: rtl/async_fifo16_wr_arbiter_if.sv
// Requester/FIFO-facing signal bundle of the write arbiter; master is the arbiter side.
interface async_fifo16_wr_arbiter_if #(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = 1,
   parameter int unsigned CW     = async_lib_pkg::CREDIT_W
);

   logic [N-1:0]        REQ;
   logic [N*DATA_W-1:0] REQ_DATA;
   logic [N-1:0]        GNT;
   logic [DATA_W-1:0]   DIN;
   logic                DIN_DV;
   logic                CREDIT_RET;
   logic [CW-1:0]       CREDITS;
   logic                FIFO_FULL;
   logic                OVF_ERR;

   modport master (
      input  REQ, REQ_DATA, CREDIT_RET,
      output GNT, DIN, DIN_DV, CREDITS, FIFO_FULL, OVF_ERR
   );

   modport slave (
      output REQ, REQ_DATA, CREDIT_RET,
      input  GNT, DIN, DIN_DV, CREDITS, FIFO_FULL, OVF_ERR
   );

endinterface

// File: rtl/async_fifo16_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first unmasked request at or above ptr_i, wrapping at N.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [N-1:0]  mask_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   logic [N-1:0] elig;

   assign elig = req_i & ~mask_i;

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      return PW'(s % N);
   endfunction

   always_comb begin
      logic [PW-1:0] k;
      k       = '0;
      gnt_o   = '0;
      valid_o = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         k = wrap_idx(ptr_i, i);
         if (!valid_o && elig[k]) begin
            gnt_o[k] = 1'b1;
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/async_fifo16_wr_arbiter.sv
// Round-robin arbiter sharing the async_fifo16 write port among N requesters,
// with credit-based flow control and a fixed idle gap after every write.
module async_fifo16_wr_arbiter
   import async_lib_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = 1,
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned WR_GAP = 1
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   async_fifo16_wr_arbiter_if.master  bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(N);

   wr_state_e         state_q;
   logic [PW-1:0]     ptr_q, ptr_d, win_idx;
   logic [GAP_W-1:0]  gap_q;
   logic [CW-1:0]     credits_q, credits_d;
   logic              ovf_q, ovf_d;
   logic [N-1:0]      gnt_q, mask, win;
   logic [DATA_W-1:0] din_q, win_data;
   logic              dv_q, win_vld, arb_slot, take;

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req_i   (bus.REQ),
      .mask_i  (mask),
      .ptr_i   (ptr_q),
      .gnt_o   (win),
      .valid_o (win_vld)
   );

   always_comb begin
      // The requester on the bus this cycle cannot win the very next back-to-back slot.
      mask     = (state_q == ST_WRITE) ? gnt_q : '0;
      // The last GAP cycle arbitrates directly so writes are spaced exactly 1+WR_GAP apart.
      arb_slot = (state_q == ST_IDLE)
              || (state_q == ST_WRITE && WR_GAP == 0)
              || (state_q == ST_GAP && gap_q == GAP_W'(1));
      take     = arb_slot && win_vld && (credits_q != '0);

      win_idx  = '0;
      win_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (win[k]) begin
            win_idx  = PW'(k);
            win_data = bus.REQ_DATA[k*DATA_W +: DATA_W];
         end
      end
      ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;

      credits_d = credits_q;
      ovf_d     = ovf_q;
      if (bus.CREDIT_RET && !take) begin
         if (credits_q == CW'(DEPTH)) ovf_d = 1'b1;
         else                         credits_d = credits_q + 1'b1;
      end else if (!bus.CREDIT_RET && take) begin
         credits_d = credits_q - 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gap_q     <= '0;
         credits_q <= CW'(DEPTH);
         ovf_q     <= 1'b0;
         gnt_q     <= '0;
         din_q     <= '0;
         dv_q      <= 1'b0;
      end else begin
         credits_q <= credits_d;
         ovf_q     <= ovf_d;
         gnt_q     <= take ? win : '0;
         din_q     <= take ? win_data : '0;
         dv_q      <= take;
         if (take) ptr_q <= ptr_d;
         case (state_q)
            ST_IDLE:  if (take) state_q <= ST_WRITE;
            ST_WRITE: begin
               if (WR_GAP != 0) begin
                  state_q <= ST_GAP;
                  gap_q   <= GAP_W'(WR_GAP);
               end else begin
                  state_q <= take ? ST_WRITE : ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_q == GAP_W'(1)) state_q <= take ? ST_WRITE : ST_IDLE;
               else                    gap_q   <= gap_q - 1'b1;
            end
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.GNT       = gnt_q;
   assign bus.DIN       = din_q;
   assign bus.DIN_DV    = dv_q;
   assign bus.CREDITS   = credits_q;
   assign bus.FIFO_FULL = (credits_q == '0);
   assign bus.OVF_ERR   = ovf_q;

endmodule

// File: tb/tb_async_fifo16_wr_arbiter.sv
// Bench for async_fifo16_wr_arbiter: two instances (WR_GAP=1 and WR_GAP=0) driven
// by shared stimulus and checked every cycle against a cycle-level reference model.
module tb_async_fifo16_wr_arbiter;

   localparam int unsigned N = 4, DW = 1, DEPTH = 16, CW = 5;

   int checks   = 0;
   int failures = 0;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b1;
   logic [N-1:0]     req      = '0;
   logic [N*DW-1:0]  req_data = '0;
   logic             cret     = 1'b0;

   always #5 clk = ~clk;

   async_fifo16_wr_arbiter_if #(.N(N), .DATA_W(DW), .CW(CW)) bus_a ();
   async_fifo16_wr_arbiter_if #(.N(N), .DATA_W(DW), .CW(CW)) bus_b ();

   assign bus_a.REQ        = req;
   assign bus_a.REQ_DATA   = req_data;
   assign bus_a.CREDIT_RET = cret;
   assign bus_b.REQ        = req;
   assign bus_b.REQ_DATA   = req_data;
   assign bus_b.CREDIT_RET = cret;

   async_fifo16_wr_arbiter #(.N(N), .DATA_W(DW), .DEPTH(DEPTH), .WR_GAP(1)) u_a (
      .CLK (clk), .RST_N (rst_n), .bus (bus_a.master)
   );
   async_fifo16_wr_arbiter #(.N(N), .DATA_W(DW), .DEPTH(DEPTH), .WR_GAP(0)) u_b (
      .CLK (clk), .RST_N (rst_n), .bus (bus_b.master)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a write may start when the cool-down is over and credits remain;
   // the winner is the first requester at or after the pointer (back-to-back repeat barred).
   int              m_cred [2];
   int              m_ptr  [2];
   int              m_cool [2];
   int              m_last [2];
   bit              m_ovf  [2];
   logic [N-1:0]    e_gnt  [2];
   logic [DW-1:0]   e_din  [2];
   logic            e_dv   [2];

   function automatic int gap_of(input int u);
      return (u == 0) ? 1 : 0;
   endfunction

   task automatic model_step(input int u);
      logic [N-1:0] elig;
      int win, nc;
      elig = req;
      if (gap_of(u) == 0 && m_last[u] >= 0) elig[m_last[u]] = 1'b0;
      win = -1;
      if (m_cool[u] == 0 && m_cred[u] > 0) begin
         for (int j = 0; j < int'(N); j++) begin
            int k;
            k = (m_ptr[u] + j) % int'(N);
            if (win < 0 && elig[k]) win = k;
         end
      end
      nc = m_cred[u] + int'(cret) - ((win >= 0) ? 1 : 0);
      if (nc > int'(DEPTH)) begin
         nc       = int'(DEPTH);
         m_ovf[u] = 1'b1;
      end
      m_cred[u] = nc;
      e_gnt[u]  = '0;
      if (win >= 0) begin
         e_gnt[u][win] = 1'b1;
         e_din[u]      = req_data[win*DW +: DW];
         e_dv[u]       = 1'b1;
         m_ptr[u]      = (win + 1) % int'(N);
         m_cool[u]     = gap_of(u);
      end else begin
         e_din[u] = '0;
         e_dv[u]  = 1'b0;
         if (m_cool[u] > 0) m_cool[u]--;
      end
      m_last[u] = win;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int u = 0; u < 2; u++) begin
            m_cred[u] = int'(DEPTH);
            m_ptr[u]  = 0;
            m_cool[u] = 0;
            m_last[u] = -1;
            m_ovf[u]  = 1'b0;
            e_gnt[u]  = '0;
            e_din[u]  = '0;
            e_dv[u]   = 1'b0;
         end
      end else begin
         for (int u = 0; u < 2; u++) model_step(u);
      end
   end

   always @(negedge clk) begin
      chk("A_GNT",   bus_a.GNT,       e_gnt[0]);
      chk("A_DIN",   bus_a.DIN,       e_din[0]);
      chk("A_DV",    bus_a.DIN_DV,    e_dv[0]);
      chk("A_CRED",  bus_a.CREDITS,   m_cred[0]);
      chk("A_FULL",  bus_a.FIFO_FULL, (m_cred[0] == 0) ? 1 : 0);
      chk("A_OVF",   bus_a.OVF_ERR,   m_ovf[0]);
      chk("B_GNT",   bus_b.GNT,       e_gnt[1]);
      chk("B_DIN",   bus_b.DIN,       e_din[1]);
      chk("B_DV",    bus_b.DIN_DV,    e_dv[1]);
      chk("B_CRED",  bus_b.CREDITS,   m_cred[1]);
      chk("B_FULL",  bus_b.FIFO_FULL, (m_cred[1] == 0) ? 1 : 0);
      chk("B_OVF",   bus_b.OVF_ERR,   m_ovf[1]);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_credits_a(input int target);
      int n;
      n = 0;
      while (int'(bus_a.CREDITS) != target && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_credits_a", bus_a.CREDITS, target);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] fair_a [9];
      logic [N-1:0] fair_b [5];
      fair_a = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      fair_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick(5);
      chk("rst_credits", bus_a.CREDITS, 16);
      chk("rst_full",    bus_a.FIFO_FULL, 0);
      chk("rst_ovf",     bus_a.OVF_ERR, 0);
      chk("rst_gnt",     bus_a.GNT, 0);
      chk("rst_dv",      bus_a.DIN_DV, 0);

      // single requester
      req_data = 4'b0010;
      req      = 4'b0010;
      tick(1);
      chk("single_gnt",   bus_a.GNT, 4'b0010);
      chk("single_din",   bus_a.DIN, 1);
      chk("single_dv",    bus_a.DIN_DV, 1);
      chk("single_cred",  bus_a.CREDITS, 15);
      chk("single_b_gnt", bus_b.GNT, 4'b0010);
      tick(1);
      chk("single_gap_dv",  bus_a.DIN_DV, 0);
      chk("single_b_mask",  bus_b.GNT, 0);
      tick(1);
      chk("single_dv2",     bus_a.DIN_DV, 1);
      chk("single_cred2",   bus_a.CREDITS, 14);
      chk("single_b_gnt2",  bus_b.GNT, 4'b0010);
      req = '0;
      tick(3);

      // fairness
      do_reset();
      req      = '1;
      req_data = N'($urandom);
      for (int c = 0; c < 9; c++) begin
         tick(1);
         chk("fair_a", bus_a.GNT, fair_a[c]);
         if (c < 5) chk("fair_b", bus_b.GNT, fair_b[c]);
      end

      // credit exhaustion and single return
      do_reset();
      req = '1;
      tick(40);
      chk("exh_credits", bus_a.CREDITS, 0);
      chk("exh_full",    bus_a.FIFO_FULL, 1);
      repeat (4) begin
         tick(1);
         chk("exh_no_gnt", bus_a.GNT, 0);
      end
      cret = 1'b1;
      tick(1);
      cret = 1'b0;
      chk("ret_credits", bus_a.CREDITS, 1);
      chk("ret_no_gnt",  bus_a.GNT, 0);
      tick(1);
      chk("ret_gnt",     bus_a.GNT, 4'b0001);
      chk("ret_credits0", bus_a.CREDITS, 0);
      tick(2);
      chk("ret_one_only", bus_a.GNT, 0);

      // simultaneous return and write, then overflow
      do_reset();
      req = '1;
      wait_credits_a(5);
      req = '0;
      tick(3);
      chk("sim_pre", bus_a.CREDITS, 5);
      req      = 4'b0100;
      req_data = 4'b0100;
      cret     = 1'b1;
      tick(1);
      cret = 1'b0;
      req  = '0;
      chk("sim_gnt",     bus_a.GNT, 4'b0100);
      chk("sim_din",     bus_a.DIN, 1);
      chk("sim_credits", bus_a.CREDITS, 5);
      cret = 1'b1;
      tick(11);
      chk("ovf_pre_cred", bus_a.CREDITS, 16);
      chk("ovf_pre",      bus_a.OVF_ERR, 0);
      tick(1);
      chk("ovf_cred",     bus_a.CREDITS, 16);
      chk("ovf_set",      bus_a.OVF_ERR, 1);
      cret = 1'b0;
      tick(3);
      chk("ovf_sticky",   bus_a.OVF_ERR, 1);
      do_reset();
      chk("ovf_cleared",  bus_a.OVF_ERR, 0);

      // reset in the middle of a write
      req = '1;
      wait_credits_a(9);
      chk("mid_dv_pre", bus_a.DIN_DV, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_dv",      bus_a.DIN_DV, 0);
      chk("mid_gnt",     bus_a.GNT, 0);
      chk("mid_credits", bus_a.CREDITS, 16);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      chk("mid_restart", bus_a.GNT, 4'b0001);

      // randomized traffic
      do_reset();
      req = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < int'(N); i++) begin
            if (req[i] && bus_a.GNT[i]) begin
               req[i]      = 1'($urandom % 2);
               req_data[i] = 1'($urandom % 2);
            end else if (!req[i]) begin
               req[i]      = ($urandom % 4) == 0;
               req_data[i] = 1'($urandom % 2);
            end
         end
         cret = ($urandom % 100) < ((((c / 500) % 2) == 1) ? 60 : 15);
      end
      cret = 1'b0;
      req  = '0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
